// File: rtl/ysyx_23060124_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU data-memory arbiter: FSM states, owner IDs,
// grant bit positions and the default watchdog limit.
package ysyx_23060124_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

    // Bit positions inside the one-hot grant vector; they match the owner codes.
    localparam int GRANT_IFU = 0;
    localparam int GRANT_LSU = 1;

    localparam int ARB_TIMEOUT_DEFAULT = 255;

    function automatic owner_e grant_to_owner(input logic [1:0] grant);
        return grant[GRANT_LSU] ? OWNER_LSU : OWNER_IFU;
    endfunction

endpackage

// File: rtl/ysyx_23060124_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, on contention
// the requester that was not granted last wins. Output is one-hot {lsu, ifu}.
module ysyx_23060124_rr_pick2
    import ysyx_23060124_mem_arbiter_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  owner_e     last_grant,
    output logic [1:0] grant
);

    logic [1:0] req;

    assign req = {lsu_valid, ifu_valid};

    for (genvar gi = 0; gi < 2; gi++) begin : g_pick
        assign grant[gi] = req[gi] && (!req[1-gi] || (last_grant != owner_e'(1'(gi))));
    end

endmodule

// File: rtl/ysyx_23060124_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU.
// Optional watchdog abort is enabled by defining YSYX_23060124_ARB_TIMEOUT_EN.
module ysyx_23060124_mem_arbiter
    import ysyx_23060124_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err
);

    localparam int MASK_W = DATA_W / 8;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("ysyx_23060124_mem_arbiter: DATA_W must be 32");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("ysyx_23060124_mem_arbiter: TIMEOUT_CYCLES must be 1..255");
    end

    arb_state_e state_reg, state_next;
    owner_e     owner_reg;
    owner_e     last_grant_reg;

    logic [ADDR_W-1:0]            addr_reg;
    logic                         wen_reg;
    logic [DATA_W-1:0]            wdata_reg;
    logic [MASK_W-1:0]            wmask_reg;
    logic [1:0][DATA_W-1:0]       rsp_data_reg;
    logic [1:0]                   rsp_err_reg;

    logic [1:0] grant;
    logic       accept;
    logic       rsp_capture;
    logic       timeout_hit;

    ysyx_23060124_rr_pick2 u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    // Requests are only taken in IDLE and never while reset is held.
    assign accept = (state_reg == ARB_IDLE) && !reset && (grant != 2'b00);

    // A response counts only once the request has been handed to memory.
    assign rsp_capture = mem_rsp_valid &&
                         (((state_reg == ARB_ISSUE) && mem_req_ready) ||
                          (state_reg == ARB_WAIT));

`ifdef YSYX_23060124_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_reg <= 8'd0;
        end else if (accept) begin
            tmo_cnt_reg <= 8'd0;
        end else if (((state_reg == ARB_ISSUE) || (state_reg == ARB_WAIT)) &&
                     (tmo_cnt_reg != 8'hFF)) begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
        end
    end

    // Fires on the cycle whose increment would make the counter reach the limit.
    assign timeout_hit = ((state_reg == ARB_ISSUE) || (state_reg == ARB_WAIT)) &&
                         (tmo_cnt_reg == TIMEOUT_LAST) && !rsp_capture;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (accept) begin
                    state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (rsp_capture || timeout_hit) begin
                    state_next = ARB_RESP;
                end else if (mem_req_ready) begin
                    state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (rsp_capture || timeout_hit) begin
                    state_next = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        ifu_req_ready = accept && grant[GRANT_IFU];
        lsu_req_ready = accept && grant[GRANT_LSU];
        mem_req_valid = !reset && (state_reg == ARB_ISSUE);
        ifu_rsp_valid = !reset && (state_reg == ARB_RESP) && (owner_reg == OWNER_IFU);
        lsu_rsp_valid = !reset && (state_reg == ARB_RESP) && (owner_reg == OWNER_LSU);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_reg      <= OWNER_IFU;
            last_grant_reg <= OWNER_IFU;
            addr_reg       <= '0;
            wen_reg        <= 1'b0;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= '0;
        end else begin
            if (accept) begin
                owner_reg <= grant_to_owner(grant);
                if (grant[GRANT_LSU]) begin
                    addr_reg  <= lsu_addr;
                    wen_reg   <= lsu_wen;
                    wdata_reg <= lsu_wdata;
                    wmask_reg <= lsu_wmask;
                end else begin
                    addr_reg  <= ifu_addr;
                    wen_reg   <= 1'b0;
                    wdata_reg <= '0;
                    wmask_reg <= '0;
                end
            end
            // Each port keeps its own response so the other side's data never shifts.
            if (rsp_capture) begin
                rsp_data_reg[owner_reg] <= mem_rsp_data;
                rsp_err_reg[owner_reg]  <= mem_rsp_err;
            end else if (timeout_hit) begin
                rsp_data_reg[owner_reg] <= '0;
                rsp_err_reg[owner_reg]  <= 1'b1;
            end
            if (state_reg == ARB_RESP) begin
                last_grant_reg <= owner_reg;
            end
        end
    end

    assign mem_addr     = addr_reg;
    assign mem_wen      = wen_reg;
    assign mem_wdata    = wdata_reg;
    assign mem_wmask    = wmask_reg;
    assign ifu_rsp_data = rsp_data_reg[GRANT_IFU];
    assign ifu_rsp_err  = rsp_err_reg[GRANT_IFU];
    assign lsu_rsp_data = rsp_data_reg[GRANT_LSU];
    assign lsu_rsp_err  = rsp_err_reg[GRANT_LSU];

endmodule

// File: tb/tb_ysyx_23060124_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter with a transaction-level model
// (expected-request registers plus a response queue) checked every negedge.
module tb_ysyx_23060124_mem_arbiter;

`ifdef YSYX_23060124_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif
    localparam bit M_IFU = 1'b0;
    localparam bit M_LSU = 1'b1;

    logic        clock, reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [3:0]  mem_wmask;

    ysyx_23060124_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          owner;
        logic [31:0] data;
        bit          err;
    } rsp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          m_last;
    rsp_t        exp_q[$];
    rsp_t        cmp_e;
    bit          exp_req_active;
    logic [31:0] exp_addr, exp_wdata;
    bit          exp_wen;
    logic [3:0]  exp_wmask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model comparison: request fields while memory is asked, responses as they pulse.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_req_valid) begin
                if (!exp_req_active) begin
                    check("mem_req_valid_unexpected", 32'(mem_req_valid), 32'd0);
                end else begin
                    check("mem_addr", mem_addr, exp_addr);
                    check("mem_wen", 32'(mem_wen), 32'(exp_wen));
                    check("mem_wdata", mem_wdata, exp_wdata);
                    check("mem_wmask", 32'(mem_wmask), 32'(exp_wmask));
                end
            end
            if (ifu_rsp_valid || lsu_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("rsp_ifu_valid", 32'(ifu_rsp_valid), 32'(cmp_e.owner == M_IFU));
                    check("rsp_lsu_valid", 32'(lsu_rsp_valid), 32'(cmp_e.owner == M_LSU));
                    if (cmp_e.owner == M_IFU) begin
                        check("ifu_rsp_data", ifu_rsp_data, cmp_e.data);
                        check("ifu_rsp_err", 32'(ifu_rsp_err), 32'(cmp_e.err));
                    end else begin
                        check("lsu_rsp_data", lsu_rsp_data, cmp_e.data);
                        check("lsu_rsp_err", 32'(lsu_rsp_err), 32'(cmp_e.err));
                    end
                end
            end
        end
    end

    // Called at posedge+1; holds reset across two edges and checks the cleared outputs.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_req_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        check("rst_ifu_rsp_data", ifu_rsp_data, 32'd0);
        check("rst_lsu_rsp_data", lsu_rsp_data, 32'd0);
        check("rst_rsp_err", {30'd0, ifu_rsp_err, lsu_rsp_err}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        exp_req_active = 1'b0;
        m_last = M_IFU;
    endtask

    // One full transaction starting in IDLE at posedge+1. stall = cycles with
    // mem_req_ready low; rdly = cycles from the ready cycle to the response cycle.
    task automatic do_txn(input bit iv, input logic [31:0] ia,
                          input bit lv, input logic [31:0] la, input bit lw,
                          input logic [31:0] lwd, input logic [3:0] lwm,
                          input int stall, input int rdly,
                          input logic [31:0] rdata, input bit rerr);
        bit   win;
        rsp_t e;
        win = (iv && lv) ? ~m_last : lv;
        ifu_req_valid = iv; ifu_addr = ia;
        lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lwm;
        if (win) begin
            exp_addr = la; exp_wen = lw; exp_wdata = lwd; exp_wmask = lwm;
        end else begin
            exp_addr = ia; exp_wen = 1'b0; exp_wdata = 32'd0; exp_wmask = 4'd0;
        end
        exp_req_active = 1'b1;
        e.owner = win; e.data = rdata; e.err = rerr;
        exp_q.push_back(e);
        @(negedge clock);
        check("req_ready_ifu", 32'(ifu_req_ready), 32'(win == M_IFU));
        check("req_ready_lsu", 32'(lsu_req_ready), 32'(win == M_LSU));
        @(posedge clock); #1;
        // Winner withdraws and scrambles its bus; the latched copy must not move.
        if (win) begin
            lsu_req_valid = 1'b0; lsu_addr = ~la; lsu_wdata = ~lwd; lsu_wmask = ~lwm;
        end else begin
            ifu_req_valid = 1'b0; ifu_addr = ~ia;
        end
        for (int c = 0; c < stall; c++) begin
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0BAD0;
            @(negedge clock);
            check("stall_req_valid", 32'(mem_req_valid), 32'd1);
            check("stall_no_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
            @(posedge clock); #1;
        end
        mem_req_ready = 1'b1;
        mem_rsp_valid = (rdly == 0);
        mem_rsp_data  = rdata;
        mem_rsp_err   = (rdly == 0) ? rerr : 1'b0;
        @(negedge clock);
        check("issue_req_valid", 32'(mem_req_valid), 32'd1);
        check("busy_no_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
        @(posedge clock); #1;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        mem_rsp_data = 32'hBAD1BAD1; exp_req_active = 1'b0;
        if (rdly > 0) begin
            for (int c = 1; c < rdly; c++) begin
                @(negedge clock);
                check("wait_no_rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
                @(posedge clock); #1;
            end
            mem_rsp_valid = 1'b1; mem_rsp_data = rdata; mem_rsp_err = rerr;
            @(negedge clock);
            check("wait_no_rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
            @(posedge clock); #1;
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = 32'hBAD2BAD2;
        end
        @(negedge clock);
        check("rsp_pulse", 32'(win ? lsu_rsp_valid : ifu_rsp_valid), 32'd1);
        @(posedge clock); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        m_last = win;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD3BAD3;   // stray response in IDLE
        @(negedge clock);
        check("rsp_one_cycle", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        @(posedge clock); #1;
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = 32'd0;
        lsu_req_valid = 1'b0; lsu_addr = 32'd0; lsu_wen = 1'b0;
        lsu_wdata = 32'd0; lsu_wmask = 4'd0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; mem_rsp_err = 1'b0;
        exp_req_active = 1'b0; m_last = M_IFU;
        do_reset();

        // Contention from reset: LSU, IFU, LSU, IFU.
        for (int k = 0; k < 4; k++) begin
            do_txn(1'b1, 32'h80000100 + 32'(k * 4), 1'b1, 32'h80001100 + 32'(k * 4),
                   1'b0, 32'd0, 4'hF, 0, 1, 32'h10000000 + 32'(k), 1'b0);
            $display("[TB] contention round %0d winner %s", k, m_last ? "LSU" : "IFU");
        end
        check("alt_last_is_ifu", 32'(m_last), 32'(M_IFU));

        do_txn(1'b1, 32'h80000000, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 0, 2, 32'h00000413, 1'b0);
        $display("[TB] ifu read 0x80000000 done");
        do_txn(1'b0, 32'd0, 1'b1, 32'h80001000, 1'b1, 32'hDEADBEEF, 4'b0011, 3, 1, 32'h0, 1'b0);
        $display("[TB] lsu store 0x80001000 done");
        do_txn(1'b0, 32'd0, 1'b1, 32'h80001004, 1'b0, 32'd0, 4'hF, 0, 0, 32'h12345678, 1'b0);
        $display("[TB] same-cycle ready/response done");
        do_txn(1'b1, 32'h80000008, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 1, 1, 32'hFFFFFFFF, 1'b1);
        $display("[TB] ifu error response done");

        // Reset while waiting for a store response, then a late response.
        lsu_req_valid = 1'b1; lsu_addr = 32'h80002000; lsu_wen = 1'b1;
        lsu_wdata = 32'hCAFEF00D; lsu_wmask = 4'hF;
        exp_addr = 32'h80002000; exp_wen = 1'b1; exp_wdata = 32'hCAFEF00D; exp_wmask = 4'hF;
        exp_req_active = 1'b1;
        @(negedge clock);
        check("rstwait_lsu_ready", 32'(lsu_req_ready), 32'd1);
        @(posedge clock); #1;
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clock); #1;
        mem_req_ready = 1'b0; exp_req_active = 1'b0;
        @(negedge clock);
        check("rstwait_in_wait", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        @(posedge clock); #1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        do_reset();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55AA55AA; mem_rsp_err = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("late_rsp_ignored", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
            @(posedge clock); #1;
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        end
        check("late_rsp_lsu_data", lsu_rsp_data, 32'd0);
        check("late_rsp_mem_req", 32'(mem_req_valid), 32'd0);
        $display("[TB] reset in WAIT done");
        do_txn(1'b1, 32'h80000004, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 0, 1, 32'h00100073, 1'b0);
        $display("[TB] post-reset ifu read done");

`ifdef YSYX_23060124_ARB_TIMEOUT_EN
        begin
            rsp_t e;
            lsu_req_valid = 1'b1; lsu_addr = 32'h80003000; lsu_wen = 1'b0;
            lsu_wdata = 32'd0; lsu_wmask = 4'hF;
            exp_addr = 32'h80003000; exp_wen = 1'b0; exp_wdata = 32'd0; exp_wmask = 4'hF;
            exp_req_active = 1'b1;
            e.owner = M_LSU; e.data = 32'd0; e.err = 1'b1;
            exp_q.push_back(e);
            @(negedge clock);
            check("tmo_lsu_ready", 32'(lsu_req_ready), 32'd1);
            @(posedge clock); #1;
            lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                @(posedge clock); #1;
                if (k == 1) begin
                    mem_req_ready = 1'b0; exp_req_active = 1'b0;
                end
                @(negedge clock);
                check("tmo_rsp_timing", 32'(lsu_rsp_valid), 32'(k == 8));
            end
            check("tmo_rsp_data", lsu_rsp_data, 32'd0);
            check("tmo_rsp_err", 32'(lsu_rsp_err), 32'd1);
            @(posedge clock); #1;
            m_last = M_LSU;
            @(negedge clock);
            check("tmo_back_idle", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
            @(posedge clock); #1;
            $display("[TB] watchdog abort done");
            do_txn(1'b0, 32'd0, 1'b1, 32'h80003004, 1'b0, 32'd0, 4'hF, 0, 1, 32'hA5A5A5A5, 1'b0);
            $display("[TB] post-timeout lsu load done");
        end
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060124_mem_arbiter.md
Name: ysyx_23060124_mem_arbiter

Overview:
- Shares the single data-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the IFU/LSU and the memory bridge.
- Accepts one transaction at a time, forwards it to memory, waits for the response and routes it back to the winning requester.
- Alternates grant on contention so that neither unit starves.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (must be 32; wmask is DATA_W/8)
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_rsp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_rsp_data  out  DATA_W  fetched word
- ifu_rsp_err  out  1  error response
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte strobes
- lsu_rsp_valid  out  1  one-cycle pulse, load data or store done
- lsu_rsp_data  out  DATA_W  raw load word (sign/zero extension is done in the LSU)
- lsu_rsp_err  out  1  error response
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts
- mem_addr  out  ADDR_W  address
- mem_wen  out  1  write enable
- mem_wdata  out  DATA_W  write data
- mem_wmask  out  DATA_W/8  strobes
- mem_rsp_valid  in  1  memory response
- mem_rsp_data  in  DATA_W  read data
- mem_rsp_err  in  1  memory error

Behaviour:
- States:
  - IDLE: no transaction in flight
  - ISSUE: mem_req_valid=1, holding the latched request
  - WAIT: awaiting mem_rsp_valid
  - RESP: drive the owner's rsp_valid for exactly one cycle
- IDLE:
  - req_ready is asserted combinationally to the selected requester only.
  - Selection: if only one requester is valid, it wins. If both are valid, the one not granted last wins (last_grant flag; reset value = IFU, so the LSU wins the first contention).
  - Handshake fires when valid&&ready. Address, wen, wdata, wmask and owner are latched. Next state = ISSUE.
- ISSUE:
  - mem_* are driven from the latched registers and are stable until mem_req_ready.
  - On mem_req_ready: go to WAIT.
  - If mem_rsp_valid arrives in the same cycle as mem_req_ready, capture it and go directly to RESP.
- WAIT:
  - On mem_rsp_valid: capture data and err, go to RESP.
- RESP:
  - The owner's rsp_valid=1, with rsp_data/rsp_err from the captured values.
  - The non-owner's rsp_valid stays 0.
  - Next state = IDLE; last_grant is updated to the owner.
- Minimum latency:
  - IFU/LSU request accepted at cycle 0, mem_req_valid at cycle 1.
  - With mem_req_ready and mem_rsp_valid both asserted at cycle 1, rsp_valid rises at cycle 2.
- No new request is accepted outside IDLE (both req_ready=0). Requesters hold their valid signals.
- Reset (at any time, including mid-transaction):
  - state=IDLE, last_grant=IFU.
  - All out valid/ready = 0; mem_addr/wdata/wmask/wen = 0; rsp_data = 0, rsp_err = 0.
  - An in-flight response arriving after reset is ignored.
- An unexpected mem_rsp_valid in IDLE or ISSUE-without-ready is ignored.
- rsp_data holds its last value when rsp_valid=0.

Optional Feature:
- Macro: YSYX_23060124_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - When it reaches TIMEOUT_CYCLES, go to RESP with rsp_err=1 and rsp_data=0, abandoning the transaction.
  - The counter saturates and resets to 0 on reset.
- Without the macro: no counter; ISSUE/WAIT may wait indefinitely.

Decomposition:
- Shared package/defines file (para_defines.v) carries:
  - state encodings ARB_IDLE/ISSUE/WAIT/RESP (2 bits)
  - owner encoding OWNER_IFU=0, OWNER_LSU=1
  - default TIMEOUT_CYCLES
- One natural sub-module: ysyx_23060124_rr_pick2. It is a combinational two-input round-robin picker that takes the valid signals and last_grant and produces a one-hot grant.

Test Plan:
- IFU-only read, addr 0x80000000; memory ready at once, responds 0x00000413 after 2 cycles -> ifu_rsp_valid one pulse with 0x00000413; lsu_rsp_valid stays 0.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0b0011 -> mem_wen=1, mem_wmask=0011, data stable across 3 stall cycles of mem_req_ready=0; lsu_rsp_valid pulse, err=0.
- Both requesters valid continuously from reset -> grants alternate LSU, IFU, LSU, IFU; each completes before the next req_ready.
- Same-cycle mem_req_ready and mem_rsp_valid (data 0x12345678) -> RESP next cycle, owner receives 0x12345678.
- Reset asserted in WAIT, then a late mem_rsp_valid -> no rsp_valid on either port, all outputs 0, next request is served normally.
- With YSYX_23060124_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never responds -> rsp_valid with err=1 and data 0 on the owner port after 8 cycles; state returns to IDLE.
